// File: rtl/bp_me_fixed_latency_mem_responder.sv
// bp_me_fixed_latency_mem_responder: fixed-latency BedRock memory responder backed by a block array.
// Optional build macro BP_ME_RESPONDER_BACKPRESSURE_EN gates idle ready with an 8-bit LFSR.
module bp_me_fixed_latency_mem_responder #(
    parameter int paddr_width_p   = 40,
    parameter int block_width_p   = 512,
    parameter int payload_width_p = 8,
    parameter int mem_els_p       = 1024,
    parameter int latency_p       = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       mem_cmd_v_i,
    output logic                       mem_cmd_ready_and_o,
    input  logic [2:0]                 mem_cmd_opcode_i,
    input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
    input  logic [2:0]                 mem_cmd_size_i,
    input  logic [payload_width_p-1:0] mem_cmd_payload_i,
    input  logic [block_width_p-1:0]   mem_cmd_data_i,
    output logic                       mem_resp_v_o,
    input  logic                       mem_resp_yumi_i,
    output logic [2:0]                 mem_resp_opcode_o,
    output logic [paddr_width_p-1:0]   mem_resp_addr_o,
    output logic [2:0]                 mem_resp_size_o,
    output logic [payload_width_p-1:0] mem_resp_payload_o,
    output logic [block_width_p-1:0]   mem_resp_data_o,
    output logic                       error_o
);
    localparam int bytes_lp    = block_width_p / 8;
    localparam int lg_bytes_lp = $clog2(bytes_lp);
    localparam int lg_bits_lp  = lg_bytes_lp + 3;
    localparam int lg_els_lp   = $clog2(mem_els_p);
    localparam int cnt_w_lp    = $clog2(latency_p + 1);

    typedef enum logic [1:0] {e_idle, e_wait, e_resp} state_e;

    state_e                    state_r;
    logic [cnt_w_lp-1:0]       cnt_r;
    logic                      ready_r;
    logic [block_width_p-1:0]  mem_r [mem_els_p];
    logic                      accept;
    logic                      is_rd;
    logic                      is_wr;
    logic [2:0]                size_eff;
    logic [lg_bytes_lp-1:0]    chunk_mask;
    logic [lg_bytes_lp-1:0]    offset;
    logic [lg_bits_lp-1:0]     bit_mask;
    logic [lg_els_lp-1:0]      index;
    logic [block_width_p-1:0]  rd_shift;
    logic [block_width_p-1:0]  wr_shift;
    logic [block_width_p-1:0]  rd_data;

`ifdef BP_ME_RESPONDER_BACKPRESSURE_EN
    logic [7:0] lfsr_r;
    // Free-running x^8+x^6+x^5+x^4+1 LFSR that randomly withholds idle ready
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            lfsr_r <= 8'h01;
        else
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
    assign mem_cmd_ready_and_o = ready_r & lfsr_r[0];
`else
    assign mem_cmd_ready_and_o = ready_r;
`endif

    assign accept     = mem_cmd_v_i & mem_cmd_ready_and_o;
    assign is_rd      = (mem_cmd_opcode_i == 3'd0) | (mem_cmd_opcode_i == 3'd2);
    assign is_wr      = (mem_cmd_opcode_i == 3'd1) | (mem_cmd_opcode_i == 3'd3);
    assign size_eff   = (mem_cmd_size_i > 3'(lg_bytes_lp)) ? 3'(lg_bytes_lp) : mem_cmd_size_i;
    assign chunk_mask = lg_bytes_lp'((32'd1 << size_eff) - 32'd1);
    assign offset     = mem_cmd_addr_i[lg_bytes_lp-1:0] & ~chunk_mask;
    assign bit_mask   = {chunk_mask, 3'b111};
    assign index      = mem_cmd_addr_i[lg_bytes_lp +: lg_els_lp];
    assign rd_shift   = mem_r[index] >> {offset, 3'b000};
    assign wr_shift   = mem_cmd_data_i << {offset, 3'b000};

    // Replicate the addressed 2^size-byte chunk across the whole block
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < block_width_p; i++)
            rd_data[i] = rd_shift[lg_bits_lp'(i) & bit_mask];
    end

    // Byte-masked array update at command accept; contents are never reset
    always_ff @(posedge clk_i) begin
        if (accept && is_wr)
            for (int b = 0; b < bytes_lp; b++)
                if ((lg_bytes_lp'(b) & ~chunk_mask) == offset)
                    mem_r[index][8*b +: 8] <= wr_shift[8*b +: 8];
    end

    // Control FSM with registered ready, response fields and sticky error
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r            <= e_idle;
            cnt_r              <= '0;
            ready_r            <= 1'b0;
            mem_resp_v_o       <= 1'b0;
            mem_resp_opcode_o  <= '0;
            mem_resp_addr_o    <= '0;
            mem_resp_size_o    <= '0;
            mem_resp_payload_o <= '0;
            mem_resp_data_o    <= '0;
            error_o            <= 1'b0;
        end else begin
            case (state_r)
                e_idle: begin
                    if (accept) begin
                        state_r            <= e_wait;
                        cnt_r              <= '0;
                        ready_r            <= 1'b0;
                        mem_resp_opcode_o  <= mem_cmd_opcode_i;
                        mem_resp_addr_o    <= mem_cmd_addr_i;
                        mem_resp_size_o    <= mem_cmd_size_i;
                        mem_resp_payload_o <= mem_cmd_payload_i;
                        mem_resp_data_o    <= is_rd ? rd_data : '0;
                        error_o            <= error_o | ~(is_rd | is_wr);
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                e_wait: begin
                    if (cnt_r == cnt_w_lp'(latency_p - 1)) begin
                        state_r      <= e_resp;
                        mem_resp_v_o <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + cnt_w_lp'(1);
                    end
                end
                e_resp: begin
                    if (mem_resp_yumi_i) begin
                        state_r      <= e_idle;
                        mem_resp_v_o <= 1'b0;
                        ready_r      <= 1'b1;
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end
endmodule
